// File: rtl/rtype_instr_encoder.sv
// Re-encodes decoded ALU requests into 32-bit MIPS R-type words and queues them in a
// DEPTH-entry in-order FIFO. It also keeps counters of delivered words and dropped illegal ops.
module rtype_instr_encoder #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_op,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             err,
    output logic [CNT_W-1:0] issued_count,
    output logic [CNT_W-1:0] err_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    // Handshake: a transfer happens on a side only in a cycle where valid && ready are both high.
    // The producer holds its data stable until that cycle. in_ready depends only on registered
    // occupancy, so a full FIFO refuses input even in a cycle where it also pops.

    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;

    logic        legal;
    logic        is_shift;
    logic [5:0]  funct;
    logic [31:0] word;
    logic        accept;
    logic        push;
    logic        pop;

    always_comb begin
        legal    = 1'b1;
        is_shift = 1'b0;
        funct    = 6'b000000;
        case (in_op)
            4'd0:    funct = 6'b100000;
            4'd1:    funct = 6'b100001;
            4'd2:    funct = 6'b100100;
            4'd3:    funct = 6'b100111;
            4'd4:    funct = 6'b100101;
            4'd5:    funct = 6'b101011;
            4'd6:    begin funct = 6'b000000; is_shift = 1'b1; end
            4'd7:    begin funct = 6'b000010; is_shift = 1'b1; end
            4'd8:    funct = 6'b100010;
            4'd9:    funct = 6'b100011;
            default: legal = 1'b0;
        endcase
        // Shifts take their operand from rt, so rs is zeroed. Non-shifts carry no shift amount.
        word = {6'b000000,
                is_shift ? 5'd0 : in_rs,
                in_rt,
                in_rd,
                is_shift ? in_shamt : 5'd0,
                funct};
    end

    assign in_ready  = (occ < OCC_W'(DEPTH));
    assign out_valid = (occ != '0);
    assign out_instr = out_valid ? mem[rd_ptr] : 32'd0;

    assign accept = in_valid && in_ready;
    assign push   = accept && legal;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occ          <= '0;
            err          <= 1'b0;
            issued_count <= '0;
            err_count    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + PTR_W'(1);
                issued_count <= issued_count + CNT_W'(1);
            end
            case ({push, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            err <= accept && !legal;
            if (accept && !legal && (err_count != '1)) begin
                err_count <= err_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_rtype_instr_encoder.sv
// Scoreboard bench for rtype_instr_encoder. A driver queues expected words and error cycles.
// A negedge monitor pops the queues and compares them with what the DUT presents.
module tb_rtype_instr_encoder;
    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [3:0]       in_op = '0;
    logic [4:0]       in_rs = '0;
    logic [4:0]       in_rt = '0;
    logic [4:0]       in_rd = '0;
    logic [4:0]       in_shamt = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_instr;
    logic             err;
    logic [CNT_W-1:0] issued_count;
    logic [CNT_W-1:0] err_count;

    rtype_instr_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .err(err), .issued_count(issued_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] exp_q[$];
    int          err_q[$];
    int          model_issued = 0;
    int          model_errs = 0;
    bit          rand_rdy = 1'b0;
    logic        exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Reference encoding built from the field positions with plain arithmetic.
    function automatic logic [31:0] ref_word(input int op, input int rs, input int rt,
                                             input int rd, input int sh);
        int funct_tab[10] = '{32, 33, 36, 39, 37, 43, 0, 2, 34, 35};
        int r = rs;
        int s = sh;
        if (op == 6 || op == 7) r = 0;
        else s = 0;
        return 32'(r * 2097152 + rt * 65536 + rd * 2048 + s * 64 + funct_tab[op]);
    endfunction

    // Monitor: counters and err are checked every cycle. Delivered words are checked against the queue.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            err_q.delete();
            model_issued = 0;
            model_errs = 0;
        end else begin
            exp_err = (err_q.size() > 0 && err_q[0] == cyc);
            if (exp_err) begin
                void'(err_q.pop_front());
                if (model_errs < CNT_MAX) model_errs++;
            end
            chk("err", {31'd0, err}, {31'd0, exp_err});
            chk("err_count", 32'(err_count), 32'(model_errs));
            chk("issued_count", 32'(issued_count), 32'(model_issued % (CNT_MAX + 1)));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_word: got 0x%08h expected none (cycle %0d)",
                             out_instr, cyc);
                end else begin
                    chk("out_instr", out_instr, exp_q.pop_front());
                end
                model_issued++;
            end
        end
    end

    // Random backpressure during the soak phase.
    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called at posedge+1. Returns at posedge+1 after the accepting edge.
    task automatic send_word(input int op, input int rs, input int rt, input int rd, input int sh,
                             input logic [31:0] expw, output int waited, output int acc_cyc);
        in_valid = 1'b1;
        in_op = op[3:0];
        in_rs = rs[4:0];
        in_rt = rt[4:0];
        in_rd = rd[4:0];
        in_shamt = sh[4:0];
        waited = 0;
        acc_cyc = -1;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: got in_ready=0 expected 1 within 50 cycles");
        end else begin
            acc_cyc = cyc;
            if (op < 10) exp_q.push_back(expw);
            else err_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send(input int op, input int rs, input int rt, input int rd, input int sh,
                        output int waited);
        int acc;
        send_word(op, rs, rt, rd, sh, (op < 10) ? ref_word(op, rs, rt, rd, sh) : 32'd0,
                  waited, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d words left expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        int w;
        int acc;
        int c_raise;

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_instr", out_instr, 32'd0);
        @(posedge clk);
        #1;

        // Directed encodings and one-cycle latency.
        out_ready = 1'b1;
        send_word(0, 1, 2, 3, 9, 32'h00221820, w, acc);
        @(negedge clk);
        chk("add_latency_valid", {31'd0, out_valid}, 32'd1);
        chk("add_word", out_instr, 32'h00221820);
        @(negedge clk);
        chk("add_issued", 32'(issued_count), 32'd1);
        @(posedge clk);
        #1;
        send_word(6, 7, 5, 4, 2, 32'h00052080, w, acc);
        send_word(9, 31, 31, 31, 3, 32'h03FFF823, w, acc);
        drain();

        // Fill to full, then a fifth push is held until the first pop.
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i, i + 1, i + 2, i + 3, i, w);
        c_raise = 0;
        fork
            send(7, 3, 9, 10, 17, w);
            begin
                @(negedge clk);
                chk("full_in_ready", {31'd0, in_ready}, 32'd0);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                c_raise = cyc;
                @(negedge clk);
                chk("full_in_ready_with_pop", {31'd0, in_ready}, 32'd0);
            end
        join
        chk("fifth_accept_cycle", 32'(acc_of_last(c_raise, w)), 32'(c_raise + 1));
        drain();
        @(negedge clk);
        chk("fill_issued", 32'(issued_count), 32'd5);
        @(posedge clk);
        #1;

        // Illegal op is dropped with an err pulse.
        reset_dut();
        out_ready = 1'b1;
        send(12, 4, 5, 6, 7, w);
        send_word(2, 1, 2, 3, 0, 32'h00221824, w, acc);
        drain();
        @(negedge clk);
        chk("illegal_err_count", 32'(err_count), 32'd1);
        chk("illegal_issued", 32'(issued_count), 32'd1);
        @(posedge clk);
        #1;

        // Mid-stream reset with input asserted.
        reset_dut();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(i + 2, 5, 6, 7, 8, w);
        reset = 1'b1;
        in_valid = 1'b1;
        in_op = 4'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_issued", 32'(issued_count), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        chk("rst_out_instr", out_instr, 32'd0);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_nothing_emitted", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;

        // Streaming at one word per cycle wraps the issued counter.
        reset_dut();
        out_ready = 1'b1;
        for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
            send($urandom_range(0, 9), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), w);
            chk("stream_no_stall", 32'(w), 32'd0);
        end
        drain();
        @(negedge clk);
        chk("stream_issued_wrap", 32'(issued_count), 32'd3);
        @(posedge clk);
        #1;

        // Random soak with illegal ops and random backpressure.
        reset_dut();
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            send($urandom_range(0, 15), $urandom_range(0, 31), $urandom_range(0, 31),
                 $urandom_range(0, 31), $urandom_range(0, 31), w);
            repeat ($urandom_range(0, 1)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        drain();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Cycle on which the held fifth request was accepted: the last entry time-stamped by the driver.
    int last_acc = -1;
    always @(negedge clk) begin
        if (in_valid && in_ready && !reset) last_acc = cyc;
    end

    function automatic int acc_of_last(input int unused_a, input int unused_b);
        return last_acc + 0 * (unused_a + unused_b);
    endfunction
endmodule
